// File: rtl/trenc_pkg.sv
// Shared constants and types for the trace encoder ATB path.
package trenc_pkg;

  localparam int unsigned ATBWIDTH  = 64;
  localparam int unsigned ATB_BYTEW = $clog2(ATBWIDTH) - 3;
  localparam int unsigned ATIDW     = 7;

  localparam logic [ATIDW-1:0] TR_ATBID_CORE0 = 7'h10;
  localparam logic [ATIDW-1:0] TR_ATBID_CORE1 = 7'h11;
  localparam logic [ATIDW-1:0] TR_ATBID_CORE2 = 7'h12;
  localparam logic [ATIDW-1:0] TR_ATBID_CORE3 = 7'h13;

  typedef enum logic {ARB_IDLE, ARB_XFER} trenc_arb_state_e;

endpackage

// File: rtl/trenc_atb_arb_if.sv
// ATB bundle between the per-core sources, the arbiter and the downstream funnel.
interface trenc_atb_arb_if import trenc_pkg::*; #(
  parameter int unsigned NUM_SRC = 4
);

  logic [NUM_SRC-1:0]           trenc_src_en_i;
  logic [NUM_SRC-1:0]           trenc_src_atvalid_i;
  logic [NUM_SRC-1:0]           trenc_src_atready_o;
  logic [NUM_SRC-1:0]           trenc_src_atlast_i;
  logic [NUM_SRC*ATBWIDTH-1:0]  trenc_src_atdata_i;
  logic [NUM_SRC*ATB_BYTEW-1:0] trenc_src_atbyte_i;
  logic [NUM_SRC*ATIDW-1:0]     trenc_src_atid_i;
  logic [NUM_SRC-1:0]           trenc_src_afvalid_o;
  logic [NUM_SRC-1:0]           trenc_src_afready_i;

  logic                         trenc_atvalid_o;
  logic                         trenc_atready_i;
  logic [ATBWIDTH-1:0]          trenc_atdata_o;
  logic [ATB_BYTEW-1:0]         trenc_atbyte_o;
  logic [ATIDW-1:0]             trenc_atid_o;
  logic                         trenc_afvalid_i;
  logic                         trenc_afready_o;

  // Arbiter side: drives the shared downstream ATB master port.
  modport master (
    input  trenc_src_en_i, trenc_src_atvalid_i, trenc_src_atlast_i,
           trenc_src_atdata_i, trenc_src_atbyte_i, trenc_src_atid_i,
           trenc_src_afready_i, trenc_atready_i, trenc_afvalid_i,
    output trenc_src_atready_o, trenc_src_afvalid_o, trenc_atvalid_o,
           trenc_atdata_o, trenc_atbyte_o, trenc_atid_o, trenc_afready_o
  );

  modport slave (
    output trenc_src_en_i, trenc_src_atvalid_i, trenc_src_atlast_i,
           trenc_src_atdata_i, trenc_src_atbyte_i, trenc_src_atid_i,
           trenc_src_afready_i, trenc_atready_i, trenc_afvalid_i,
    input  trenc_src_atready_o, trenc_src_afvalid_o, trenc_atvalid_o,
           trenc_atdata_o, trenc_atbyte_o, trenc_atid_o, trenc_afready_o
  );

endinterface

// File: rtl/trenc_rr_pick.sv
// Rotating priority picker: first requester at or above ptr, wrapping.
module trenc_rr_pick #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_SRC-1:0] gnt_oh,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_any
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = IW'((32'(ptr) + k) % NUM_SRC);
      if (!gnt_any && req[idx]) begin
        gnt_any     = 1'b1;
        gnt_idx     = idx;
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trenc_atb_arb.sv
// Round-robin ATB arbiter with whole-packet grant lock and flush fan-out/drain.
module trenc_atb_arb import trenc_pkg::*; #(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic                  trenc_gclk_i,
  input  logic                  trenc_rst_i,
  trenc_atb_arb_if.master       bus
);

  localparam int unsigned IW = $clog2(NUM_SRC);

  trenc_arb_state_e     state_q, state_d;
  logic [IW-1:0]        gnt_q, gnt_d, rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        pick_idx, gnt_idx_c;
  logic [NUM_SRC-1:0]   req_c, pick_oh, gnt_oh_c;
  logic                 pick_any, gnt_vld_c, load_en_c, acc_c, src_drained_c;

  logic                 out_vld_q;
  logic [ATBWIDTH-1:0]  out_data_q;
  logic [ATB_BYTEW-1:0] out_byte_q;
  logic [ATIDW-1:0]     out_id_q;

  logic [ATBWIDTH-1:0]  src_data [NUM_SRC];
  logic [ATB_BYTEW-1:0] src_byte [NUM_SRC];
  logic [ATIDW-1:0]     src_id   [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_data[i] = bus.trenc_src_atdata_i[i*ATBWIDTH +: ATBWIDTH];
    assign src_byte[i] = bus.trenc_src_atbyte_i[i*ATB_BYTEW +: ATB_BYTEW];
    assign src_id[i]   = bus.trenc_src_atid_i[i*ATIDW +: ATIDW];
  end

  assign req_c = bus.trenc_src_atvalid_i & bus.trenc_src_en_i;

  trenc_rr_pick #(.NUM_SRC(NUM_SRC), .IW(IW)) u_pick (
    .req     (req_c),
    .ptr     (rr_ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // Grant selection and packet-lock next state; IDLE uses the live pick.
  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    rr_ptr_d         = rr_ptr_q;
    load_en_c        = !out_vld_q || bus.trenc_atready_i;
    gnt_idx_c        = gnt_q;
    gnt_vld_c        = 1'b1;
    gnt_oh_c         = '0;
    gnt_oh_c[gnt_q]  = 1'b1;
    if (state_q == ARB_IDLE) begin
      gnt_idx_c = pick_idx;
      gnt_vld_c = pick_any;
      gnt_oh_c  = pick_oh;
    end
    acc_c = load_en_c && gnt_vld_c && bus.trenc_src_atvalid_i[gnt_idx_c];
    if (acc_c) begin
      if (bus.trenc_src_atlast_i[gnt_idx_c]) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (gnt_idx_c == IW'(NUM_SRC - 1)) ? '0 : gnt_idx_c + IW'(1);
      end else begin
        state_d = ARB_XFER;
        gnt_d   = gnt_idx_c;
      end
    end
  end

  always_ff @(posedge trenc_gclk_i) begin
    if (trenc_rst_i) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Single output stage; holds its beat while downstream stalls.
  always_ff @(posedge trenc_gclk_i) begin
    if (trenc_rst_i) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_byte_q <= '0;
      out_id_q   <= '0;
    end else if (acc_c) begin
      out_vld_q  <= 1'b1;
      out_data_q <= src_data[gnt_idx_c];
      out_byte_q <= src_byte[gnt_idx_c];
      out_id_q   <= src_id[gnt_idx_c];
    end else if (bus.trenc_atready_i) begin
      out_vld_q  <= 1'b0;
    end
  end

  assign bus.trenc_src_atready_o = {NUM_SRC{load_en_c}} & gnt_oh_c & bus.trenc_src_atvalid_i;
  assign bus.trenc_atvalid_o     = out_vld_q;
  assign bus.trenc_atdata_o      = out_data_q;
  assign bus.trenc_atbyte_o      = out_byte_q;
  assign bus.trenc_atid_o        = out_id_q;

  // Disabled sources count as already flushed.
  assign src_drained_c           = &(bus.trenc_src_afready_i | ~bus.trenc_src_en_i);
  assign bus.trenc_src_afvalid_o = {NUM_SRC{bus.trenc_afvalid_i}} & bus.trenc_src_en_i;
  assign bus.trenc_afready_o     = bus.trenc_afvalid_i && src_drained_c &&
                                   (state_q == ARB_IDLE) && !out_vld_q;

endmodule
